// File: rtl/bios_host_pkg.sv
// Shared constants and types for the boot-monitor byte protocol (host side).
package bios_host_pkg;

   localparam logic [7:0] ASCII_0       = 8'h30;
   localparam logic [7:0] ASCII_B       = 8'h42;
   localparam logic [7:0] ASCII_E       = 8'h45;
   localparam logic [7:0] ASCII_N       = 8'h4E;
   localparam logic [7:0] ASCII_R       = 8'h52;
   localparam logic [7:0] ASCII_W       = 8'h57;
   localparam logic [7:0] ASCII_X       = 8'h58;
   localparam logic [7:0] ASCII_LOWER_a = 8'h61;
   localparam logic [7:0] ASCII_LOWER_b = 8'h62;
   localparam logic [7:0] ASCII_LOWER_d = 8'h64;
   localparam logic [7:0] ASCII_LOWER_e = 8'h65;
   localparam logic [7:0] ASCII_LOWER_i = 8'h69;
   localparam logic [7:0] ASCII_LOWER_n = 8'h6E;
   localparam logic [7:0] ASCII_LOWER_o = 8'h6F;
   localparam logic [7:0] ASCII_LOWER_p = 8'h70;
   localparam logic [7:0] ASCII_LOWER_r = 8'h72;
   localparam logic [7:0] ASCII_LOWER_s = 8'h73;
   localparam logic [7:0] ASCII_LOWER_t = 8'h74;
   localparam logic [7:0] ASCII_LOWER_w = 8'h77;

   // Error codes the receiver may return instead of an acknowledge.
   localparam logic [7:0] ERR_ZERO = ASCII_0;
   localparam logic [7:0] ERR_E    = ASCII_E;
   localparam logic [7:0] ERR_X    = ASCII_X;

   typedef enum logic [2:0] {
      OpNop   = 3'd0,
      OpBoot  = 3'd1,
      OpRst   = 3'd2,
      OpWrite = 3'd3,
      OpRead  = 3'd4
   } bios_op_t;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWaitAck,
      StRecvData,
      StDone
   } bios_state_t;

   function automatic logic [7:0] expected_ack(input bios_op_t op);
      case (op)
         OpNop:   expected_ack = ASCII_N;
         OpBoot:  expected_ack = ASCII_B;
         OpRst:   expected_ack = ASCII_R;
         OpWrite: expected_ack = ASCII_W;
         OpRead:  expected_ack = ASCII_R;
         default: expected_ack = 8'h00;
      endcase
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] code);
      case (code)
         2'd0:    size_bytes = 3'd1;
         2'd1:    size_bytes = 3'd2;
         2'd2:    size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/bios_host_cmd_rom.sv
// Keyword lookup: (op, byte index) -> ASCII keyword byte and keyword length.
module bios_cmd_rom
   import bios_host_pkg::*;
(
   input  logic [2:0] op_i,
   input  logic [3:0] idx_i,
   output logic [7:0] byte_o,
   output logic [2:0] len_o
);

   logic [7:0] str [8];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         str[i] = 8'h00;
      end
      len_o = 3'd0;
      case (op_i)
         OpNop: begin
            str[0] = ASCII_LOWER_n; str[1] = ASCII_LOWER_o; str[2] = ASCII_LOWER_p;
            len_o  = 3'd3;
         end
         OpBoot: begin
            str[0] = ASCII_LOWER_b; str[1] = ASCII_LOWER_o; str[2] = ASCII_LOWER_o;
            str[3] = ASCII_LOWER_t;
            len_o  = 3'd4;
         end
         OpRst: begin
            str[0] = ASCII_LOWER_r; str[1] = ASCII_LOWER_s; str[2] = ASCII_LOWER_t;
            len_o  = 3'd3;
         end
         OpWrite: begin
            str[0] = ASCII_LOWER_w; str[1] = ASCII_LOWER_r; str[2] = ASCII_LOWER_i;
            str[3] = ASCII_LOWER_t; str[4] = ASCII_LOWER_e;
            len_o  = 3'd5;
         end
         OpRead: begin
            str[0] = ASCII_LOWER_r; str[1] = ASCII_LOWER_e; str[2] = ASCII_LOWER_a;
            str[3] = ASCII_LOWER_d;
            len_o  = 3'd4;
         end
         default: ;
      endcase
      byte_o = ({1'b0, len_o} > idx_i) ? str[idx_i[2:0]] : 8'h00;
   end

endmodule

// File: rtl/bios_host.sv
// Boot-monitor command initiator: serializes one command, then parses ack and read data.
module bios_host
   import bios_host_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        rsp_valid,
   output logic        rsp_ok,
   output logic [7:0]  rsp_code,
   output logic [31:0] rsp_rdata
);

   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   bios_state_t     state_q, state_d;
   bios_op_t        op_q, op_d;
   logic [2:0]      size_q, size_d;
   logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]      idx_q, idx_d;
   logic            tx_valid_q, tx_valid_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [7:0]      ack_q, ack_d;
   logic [31:0]     acc_q, acc_d;
   logic            rsp_ok_q, rsp_ok_d;
   logic [7:0]      rsp_code_q, rsp_code_d;
   logic [31:0]     rsp_rdata_q, rsp_rdata_d;

   // In IDLE the byte source is the live command so byte 0 can be registered at acceptance.
   logic        idle;
   logic [2:0]  src_op, src_size;
   logic [31:0] src_addr, src_wdata;
   logic [3:0]  src_idx, opnd_idx, total_len;
   logic [7:0]  kw_byte, src_byte;
   logic [2:0]  kw_len;
   logic        cmd_legal;
   logic [31:0] acc_new;

   assign idle      = (state_q == StIdle);
   assign src_op    = idle ? cmd_op : op_q;
   assign src_size  = idle ? size_bytes(cmd_size) : size_q;
   assign src_addr  = idle ? cmd_addr : addr_q;
   assign src_wdata = idle ? cmd_wdata : wdata_q;
   assign src_idx   = idle ? 4'd0 : idx_q + 4'd1;
   assign opnd_idx  = src_idx - {1'b0, kw_len};

   bios_cmd_rom u_rom (
      .op_i   (src_op),
      .idx_i  (src_idx),
      .byte_o (kw_byte),
      .len_o  (kw_len)
   );

   always_comb begin
      case (src_op)
         OpWrite: total_len = {1'b0, kw_len} + 4'd5 + {1'b0, src_size};
         OpRead:  total_len = {1'b0, kw_len} + 4'd5;
         default: total_len = {1'b0, kw_len};
      endcase
   end

   always_comb begin
      src_byte = 8'h00;
      if (src_idx < {1'b0, kw_len}) begin
         src_byte = kw_byte;
      end else begin
         case (opnd_idx)
            4'd0:    src_byte = {5'd0, src_size};
            4'd1:    src_byte = src_addr[7:0];
            4'd2:    src_byte = src_addr[15:8];
            4'd3:    src_byte = src_addr[23:16];
            4'd4:    src_byte = src_addr[31:24];
            4'd5:    src_byte = src_wdata[7:0];
            4'd6:    src_byte = src_wdata[15:8];
            4'd7:    src_byte = src_wdata[23:16];
            4'd8:    src_byte = src_wdata[31:24];
            default: src_byte = 8'h00;
         endcase
      end
   end

   always_comb begin
      case (cmd_op)
         OpNop, OpBoot, OpRst: cmd_legal = 1'b1;
         OpWrite, OpRead:      cmd_legal = (cmd_size != 2'd3);
         default:              cmd_legal = 1'b0;
      endcase
   end

   always_comb begin
      acc_new = acc_q;
      case (idx_q[1:0])
         2'd0: acc_new[7:0]   = rx_data;
         2'd1: acc_new[15:8]  = rx_data;
         2'd2: acc_new[23:16] = rx_data;
         2'd3: acc_new[31:24] = rx_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      idx_d       = idx_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      tmo_d       = tmo_q;
      ack_d       = ack_q;
      acc_d       = acc_q;
      rsp_ok_d    = rsp_ok_q;
      rsp_code_d  = rsp_code_q;
      rsp_rdata_d = rsp_rdata_q;
      if (clk_en) begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  if (cmd_legal) begin
                     op_d       = bios_op_t'(cmd_op);
                     size_d     = src_size;
                     addr_d     = cmd_addr;
                     wdata_d    = cmd_wdata;
                     idx_d      = 4'd0;
                     acc_d      = 32'h0;
                     tx_valid_d = 1'b1;
                     tx_data_d  = src_byte;
                     state_d    = StSend;
                  end else begin
                     rsp_ok_d    = 1'b0;
                     rsp_code_d  = ERR_E;
                     rsp_rdata_d = 32'h0;
                     state_d     = StDone;
                  end
               end
            end
            StSend: begin
               if (tx_ready) begin
                  if (idx_q == total_len - 4'd1) begin
                     tx_valid_d = 1'b0;
                     tx_data_d  = 8'h00;
                     tmo_d      = '0;
                     state_d    = StWaitAck;
                  end else begin
                     idx_d     = idx_q + 4'd1;
                     tx_data_d = src_byte;
                  end
               end
            end
            StWaitAck: begin
               if (rx_valid) begin
                  tmo_d = '0;
                  ack_d = rx_data;
                  if (rx_data == expected_ack(op_q) && op_q == OpRead) begin
                     idx_d   = 4'd0;
                     state_d = StRecvData;
                  end else begin
                     rsp_ok_d    = (rx_data == expected_ack(op_q));
                     rsp_code_d  = rx_data;
                     rsp_rdata_d = 32'h0;
                     state_d     = StDone;
                  end
               end else if (tmo_q == TmoLast) begin
                  rsp_ok_d    = 1'b0;
                  rsp_code_d  = 8'h00;
                  rsp_rdata_d = 32'h0;
                  state_d     = StDone;
               end else begin
                  tmo_d = tmo_q + TmoW'(1);
               end
            end
            StRecvData: begin
               if (rx_valid) begin
                  tmo_d = '0;
                  acc_d = acc_new;
                  idx_d = idx_q + 4'd1;
                  if (idx_q == {1'b0, size_q} - 4'd1) begin
                     rsp_ok_d    = 1'b1;
                     rsp_code_d  = ack_q;
                     rsp_rdata_d = acc_new;
                     state_d     = StDone;
                  end
               end else if (tmo_q == TmoLast) begin
                  rsp_ok_d    = 1'b0;
                  rsp_code_d  = 8'h00;
                  rsp_rdata_d = 32'h0;
                  state_d     = StDone;
               end else begin
                  tmo_d = tmo_q + TmoW'(1);
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         op_q        <= OpNop;
         size_q      <= 3'd0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         idx_q       <= 4'd0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         tmo_q       <= '0;
         ack_q       <= 8'h00;
         acc_q       <= 32'h0;
         rsp_ok_q    <= 1'b0;
         rsp_code_q  <= 8'h00;
         rsp_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         idx_q       <= idx_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         tmo_q       <= tmo_d;
         ack_q       <= ack_d;
         acc_q       <= acc_d;
         rsp_ok_q    <= rsp_ok_d;
         rsp_code_q  <= rsp_code_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Always accept rx so stale bytes outside a response window are drained.
   assign rx_ready  = 1'b1;
   assign cmd_ready = idle;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign rsp_valid = (state_q == StDone);
   assign rsp_ok    = rsp_ok_q;
   assign rsp_code  = rsp_code_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bios_host.sv
// Directed bench for bios_host: table of commands with expected byte streams and responses.
module tb_bios_host;

   typedef struct {
      logic [2:0]   op;
      logic [1:0]   size;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      int           ntx;
      logic [111:0] txb;
      int           nrx;
      logic [39:0]  rxb;
      logic         ok;
      logic [7:0]   code;
      logic [31:0]  rdata;
      int           gap;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, clk_en, cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [7:0]  tx_data, rx_data, rsp_code;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, rsp_valid, rsp_ok;
   logic [31:0] rsp_rdata;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[17];

   always #5 clk = ~clk;

   bios_host #(.TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_size  (cmd_size),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rsp_valid (rsp_valid),
      .rsp_ok    (rsp_ok),
      .rsp_code  (rsp_code),
      .rsp_rdata (rsp_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input bit stall, input string tag);
      int       sent = 0;
      int       k = 0;
      int       en_edges = 0;
      int       xfer_edge = 1;
      int       cyc = 0;
      bit       prev_en = 1'b1;
      bit       got_rsp = 1'b0;
      bit       prev_stall = 1'b0;
      logic [7:0] prev_data = 8'h00;
      @(negedge clk);
      check({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_size = v.size;
      cmd_addr = v.addr; cmd_wdata = v.wdata;
      clk_en = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         // Scramble command inputs to prove they were latched at acceptance.
         cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_size = 2'($urandom);
         cmd_addr = $urandom; cmd_wdata = $urandom;
         if (prev_en) en_edges++;
         if (cyc == 1 && v.ntx > 0) check({tag, " first tx_valid"}, 32'(tx_valid), 32'd1);
         if (rsp_valid) begin
            got_rsp = 1'b1;
            break;
         end
         if (prev_stall) check({tag, " tx held"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
         clk_en   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         prev_stall = 1'b0;
         if (tx_valid) begin
            if (tx_ready && clk_en) begin
               if (sent < v.ntx) check({tag, " tx byte"}, {24'd0, tx_data}, {24'd0, v.txb[111-8*sent -: 8]});
               else check({tag, " extra tx byte"}, sent, v.ntx);
               sent++;
               xfer_edge = en_edges + 1;
            end else begin
               prev_stall = 1'b1;
               prev_data  = tx_data;
            end
         end
         if (sent == v.ntx && !tx_valid && k < v.nrx) begin
            rx_valid = 1'b1;
            rx_data  = v.rxb[39-8*k -: 8];
            if (clk_en) begin
               k++;
               xfer_edge = en_edges + 1;
            end
         end else begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end
         prev_en = clk_en;
      end
      rx_valid = 1'b0;
      check({tag, " rsp seen"}, 32'(got_rsp), 32'd1);
      check({tag, " tx count"}, sent, v.ntx);
      check({tag, " rsp_ok"}, 32'(rsp_ok), 32'(v.ok));
      check({tag, " rsp_code"}, {24'd0, rsp_code}, {24'd0, v.code});
      check({tag, " rsp_rdata"}, rsp_rdata, v.rdata);
      check({tag, " edges to rsp"}, en_edges - xfer_edge, v.gap);
      if (stall) begin
         clk_en = 1'b0;
         @(negedge clk);
         check({tag, " rsp_valid held"}, 32'(rsp_valid), 32'd1);
      end
      clk_en = 1'b1;
      @(negedge clk);
      check({tag, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, " cmd_ready after"}, 32'(cmd_ready), 32'd1);
      check({tag, " rsp_code kept"}, {23'd0, rsp_ok, rsp_code}, {23'd0, v.ok, v.code});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int rsp_seen;
      vecs[0]  = '{3'd0, 2'd0, 32'h0, 32'h0, 3, {"nop", 88'h0}, 1, {"N", 32'h0},
                   1'b1, 8'h4E, 32'h0, 0};
      vecs[1]  = '{3'd3, 2'd1, 32'h0000_1000, 32'hA5A5_BEEF, 12,
                   {"write", 8'h02, 32'h0010_0000, 8'hEF, 8'hBE, 16'h0}, 1, {"W", 32'h0},
                   1'b1, 8'h57, 32'h0, 0};
      vecs[2]  = '{3'd4, 2'd2, 32'h20, 32'h0, 9, {"read", 8'h04, 32'h2000_0000, 40'h0},
                   5, {"R", 8'h78, 8'h56, 8'h34, 8'h12}, 1'b1, 8'h52, 32'h1234_5678, 0};
      vecs[3]  = '{3'd1, 2'd0, 32'h0, 32'h0, 4, {"boot", 80'h0}, 1, {"E", 32'h0},
                   1'b0, 8'h45, 32'h0, 0};
      vecs[4]  = '{3'd2, 2'd0, 32'h0, 32'h0, 3, {"rst", 88'h0}, 1, {"R", 32'h0},
                   1'b1, 8'h52, 32'h0, 0};
      vecs[5]  = '{3'd2, 2'd0, 32'h0, 32'h0, 3, {"rst", 88'h0}, 0, 40'h0,
                   1'b0, 8'h00, 32'h0, 16};
      vecs[6]  = '{3'd4, 2'd0, 32'hDEAD_BEEF, 32'h0, 9, {"read", 8'h01, 32'hEFBE_ADDE, 40'h0},
                   2, {"R", 8'h9C, 24'h0}, 1'b1, 8'h52, 32'h0000_009C, 0};
      vecs[7]  = '{3'd3, 2'd2, 32'h1234_5678, 32'hCAFE_F00D, 14,
                   {"write", 8'h04, 32'h7856_3412, 32'h0DF0_FECA}, 1, {"W", 32'h0},
                   1'b1, 8'h57, 32'h0, 0};
      vecs[8]  = '{3'd3, 2'd0, 32'h4, 32'h1234_565A, 11,
                   {"write", 8'h01, 32'h0400_0000, 8'h5A, 24'h0}, 1, {"0", 32'h0},
                   1'b0, 8'h30, 32'h0, 0};
      vecs[9]  = '{3'd4, 2'd1, 32'h0, 32'h0, 9, {"read", 8'h02, 32'h0, 40'h0}, 1, {"X", 32'h0},
                   1'b0, 8'h58, 32'h0, 0};
      vecs[10] = '{3'd0, 2'd0, 32'h0, 32'h0, 3, {"nop", 88'h0}, 1, {"W", 32'h0},
                   1'b0, 8'h57, 32'h0, 0};
      vecs[11] = '{3'd5, 2'd0, 32'h0, 32'h0, 0, 112'h0, 0, 40'h0, 1'b0, 8'h45, 32'h0, 0};
      vecs[12] = '{3'd4, 2'd3, 32'h0, 32'h0, 0, 112'h0, 0, 40'h0, 1'b0, 8'h45, 32'h0, 0};
      vecs[13] = '{3'd0, 2'd3, 32'h0, 32'h0, 3, {"nop", 88'h0}, 1, {"N", 32'h0},
                   1'b1, 8'h4E, 32'h0, 0};
      vecs[14] = '{3'd4, 2'd2, 32'h20, 32'h0, 9, {"read", 8'h04, 32'h2000_0000, 40'h0},
                   2, {"R", 8'h11, 24'h0}, 1'b0, 8'h00, 32'h0, 16};
      vecs[15] = '{3'd7, 2'd0, 32'h0, 32'h0, 0, 112'h0, 0, 40'h0, 1'b0, 8'h45, 32'h0, 0};
      vecs[16] = '{3'd3, 2'd3, 32'h0, 32'h0, 0, 112'h0, 0, 40'h0, 1'b0, 8'h45, 32'h0, 0};

      rst = 1'b1; clk_en = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_size = 2'd0;
      cmd_addr = 32'h0; cmd_wdata = 32'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset tx", {23'd0, tx_valid, tx_data}, 32'd0);
      check("reset rx_ready", 32'(rx_ready), 32'd1);
      check("reset rsp", {22'd0, rsp_valid, rsp_ok, rsp_code}, 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);

      for (int i = 0; i < 17; i++) begin
         run(vecs[i], 1'b0, $sformatf("vec%0d", i));
      end

      run(vecs[1], 1'b1, "stall write");
      run(vecs[2], 1'b1, "stall read");
      run(vecs[5], 1'b1, "stall timeout");

      // Reset in the middle of SEND: link drops, no response for the aborted command.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_size = 2'd2; cmd_addr = 32'h1; cmd_wdata = 32'h2;
      clk_en = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid-send tx_valid", 32'(tx_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst tx_valid", 32'(tx_valid), 32'd0);
      check("rst cmd_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      rsp_seen = 0;
      if (rsp_valid) rsp_seen++;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid || tx_valid) rsp_seen++;
      end
      check("rst no rsp", rsp_seen, 0);
      run(vecs[0], 1'b0, "after rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
